// File: rtl/wb_regfile_pkg.sv
// Shared pipeline package: stage constants and types used by the write-back stage.
//
// Contents:
//   WbWidth    default datapath width for register file and write-back data
//   WbAw       default register address width (2**WbAw registers)
//   ZeroReg    index of the hard-wired zero register
//   RetiredW   width of the committed-write counter
//   wb_sel_e   write-back result source select
package wb_regfile_pkg;

  localparam int unsigned WbWidth  = 32;
  localparam int unsigned WbAw     = 5;
  localparam int unsigned ZeroReg  = 0;
  localparam int unsigned RetiredW = 32;

  // Encoding matches the wb_m2reg bit: 1 selects memory data.
  typedef enum logic [0:0] {
    SelAlu = 1'b0,
    SelMem = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/regfile_core.sv
// Register storage array: one synchronous write port, two asynchronous read ports.
//
// Parameters:
//   WIDTH      register width
//   AW         address width; 2**AW registers
// Ports:
//   clk        clock, writes on rising edge
//   rst        synchronous active-high reset, clears every register
//   we_i       write enable
//   waddr_i    write address
//   wdata_i    write data
//   raddr_a_i  read address, port A
//   raddr_b_i  read address, port B
//   rdata_a_o  read data, port A (combinational)
//   rdata_b_o  read data, port B (combinational)
//
// Register ZeroReg is never written and always reads as zero.
module regfile_core
  import wb_regfile_pkg::*;
#(
  parameter int unsigned WIDTH = WbWidth,
  parameter int unsigned AW    = WbAw
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW-1:0] ZeroAddr = AW'(ZeroReg);

  logic [WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != ZeroAddr)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The zero register is masked on read as well, so it stays zero even if
  // the array were ever loaded by other means.
  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if (raddr_a_i != ZeroAddr) begin
      rdata_a_o = mem_q[raddr_a_i];
    end
    if (raddr_b_i != ZeroAddr) begin
      rdata_b_o = mem_q[raddr_b_i];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: result select, commit qualification,
// optional write-to-read bypass, retired-write counter and last-write tracking.
//
// Build option:
//   WB_BYPASS_EN  when defined, a pending commit to a register being read is
//                 forwarded to qa/qb in the same cycle; otherwise reads return
//                 the pre-edge register contents.
//
// Parameters:
//   WIDTH     data width
//   AW        register address width
// Ports:
//   clk       clock
//   clrn      synchronous active-high reset
//   wb_wreg   write-back enable
//   wb_m2reg  result select (1 = memory data D, 0 = ALU result WB_Alu)
//   wb_d      destination register
//   D         load data
//   WB_Alu    ALU result
//   stall     blocks the write and all bookkeeping this cycle
//   rna, rnb  read addresses
//   qa, qb    read data (combinational)
//   wb_data   selected write-back value (combinational)
//   retired   count of committed writes, wraps silently
//   last_d    destination of the most recent commit
//   last_v    set once any commit has happened since reset
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned WIDTH = WbWidth,
  parameter int unsigned AW    = WbAw
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                wb_wreg,
  input  logic                wb_m2reg,
  input  logic [AW-1:0]       wb_d,
  input  logic [WIDTH-1:0]    D,
  input  logic [WIDTH-1:0]    WB_Alu,
  input  logic                stall,
  input  logic [AW-1:0]       rna,
  input  logic [AW-1:0]       rnb,
  output logic [WIDTH-1:0]    qa,
  output logic [WIDTH-1:0]    qb,
  output logic [WIDTH-1:0]    wb_data,
  output logic [RetiredW-1:0] retired,
  output logic [AW-1:0]       last_d,
  output logic                last_v
);

  localparam logic [AW-1:0] ZeroAddr = AW'(ZeroReg);

  wb_sel_e          wb_sel;
  logic             commit;
  logic [WIDTH-1:0] core_qa;
  logic [WIDTH-1:0] core_qb;

  logic [RetiredW-1:0] retired_q, retired_d;
  logic [AW-1:0]       last_d_q, last_d_d;
  logic                last_v_q, last_v_d;

  // Result select.
  assign wb_sel = wb_sel_e'(wb_m2reg);

  always_comb begin
    wb_data = WB_Alu;
    unique case (wb_sel)
      SelMem:  wb_data = D;
      SelAlu:  wb_data = WB_Alu;
      default: wb_data = WB_Alu;
    endcase
  end

  // A write commits only outside reset, when not stalled and not aimed at r0.
  // A stalled write is simply dropped; the MEM/WB latch re-presents it.
  assign commit = wb_wreg && !stall && (wb_d != ZeroAddr) && !clrn;

  regfile_core #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_core (
    .clk       (clk),
    .rst       (clrn),
    .we_i      (commit),
    .waddr_i   (wb_d),
    .wdata_i   (wb_data),
    .raddr_a_i (rna),
    .raddr_b_i (rnb),
    .rdata_a_o (core_qa),
    .rdata_b_o (core_qb)
  );

`ifdef WB_BYPASS_EN
  // commit already excludes r0, so r0 can never be forwarded.
  always_comb begin
    qa = core_qa;
    qb = core_qb;
    if (commit && (wb_d == rna)) begin
      qa = wb_data;
    end
    if (commit && (wb_d == rnb)) begin
      qb = wb_data;
    end
  end
`else
  always_comb begin
    qa = core_qa;
    qb = core_qb;
  end
`endif

  // Bookkeeping next state: counter wraps naturally at full width.
  always_comb begin
    retired_d = retired_q;
    last_d_d  = last_d_q;
    last_v_d  = last_v_q;
    if (commit) begin
      retired_d = retired_q + 1'b1;
      last_d_d  = wb_d;
      last_v_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clrn) begin
      retired_q <= '0;
      last_d_q  <= '0;
      last_v_q  <= 1'b0;
    end else begin
      retired_q <= retired_d;
      last_d_q  <= last_d_d;
      last_v_q  <= last_v_d;
    end
  end

  assign retired = retired_q;
  assign last_d  = last_d_q;
  assign last_v  = last_v_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  localparam int W = 32;
  localparam int A = 5;
`ifdef WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clrn;
  logic         wb_wreg;
  logic         wb_m2reg;
  logic [A-1:0] wb_d;
  logic [W-1:0] D;
  logic [W-1:0] WB_Alu;
  logic         stall;
  logic [A-1:0] rna;
  logic [A-1:0] rnb;
  logic [W-1:0] qa;
  logic [W-1:0] qb;
  logic [W-1:0] wb_data;
  logic [31:0]  retired;
  logic [A-1:0] last_d;
  logic         last_v;

  always #5 clk = ~clk;

  wb_regfile #(
    .WIDTH (W),
    .AW    (A)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .wb_wreg  (wb_wreg),
    .wb_m2reg (wb_m2reg),
    .wb_d     (wb_d),
    .D        (D),
    .WB_Alu   (WB_Alu),
    .stall    (stall),
    .rna      (rna),
    .rnb      (rnb),
    .qa       (qa),
    .qb       (qb),
    .wb_data  (wb_data),
    .retired  (retired),
    .last_d   (last_d),
    .last_v   (last_v)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit force_pending = 1'b0;

  // Reference model: architectural register contents and bookkeeping.
  logic [W-1:0] m_regs [32];
  logic [31:0]  m_retired;
  logic [A-1:0] m_last_d;
  logic         m_last_v;

  function automatic logic m_commit();
    return wb_wreg && !stall && (wb_d != 0) && !clrn;
  endfunction

  function automatic logic [W-1:0] m_wbdata();
    return wb_m2reg ? D : WB_Alu;
  endfunction

  function automatic logic [W-1:0] m_read(input logic [A-1:0] a);
    if (a == 0) return '0;
    if (Bypass && m_commit() && (wb_d == a)) return m_wbdata();
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (clrn) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_retired <= '0;
      m_last_d  <= '0;
      m_last_v  <= 1'b0;
    end else if (m_commit()) begin
      m_regs[wb_d] <= m_wbdata();
      m_retired    <= (force_pending ? 32'hFFFF_FFFF : m_retired) + 32'd1;
      m_last_d     <= wb_d;
      m_last_v     <= 1'b1;
    end else if (force_pending) begin
      m_retired <= 32'hFFFF_FFFF;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, mid-cycle with inputs stable.
  always @(negedge clk) begin
    if (chk_en) begin
      check("wb_data", wb_data, m_wbdata());
      check("qa", qa, m_read(rna));
      check("qb", qb, m_read(rnb));
      check("retired", retired, m_retired);
      check("last_d", 32'(last_d), 32'(m_last_d));
      check("last_v", 32'(last_v), 32'(m_last_v));
    end
  end

  task automatic step(input bit r, input bit w, input bit m, input bit s, input int d,
                      input int a, input int b, input logic [W-1:0] dd,
                      input logic [W-1:0] alu);
    @(posedge clk);
    #1;
    clrn     = r;
    wb_wreg  = w;
    wb_m2reg = m;
    stall    = s;
    wb_d     = A'(d);
    rna      = A'(a);
    rnb      = A'(b);
    D        = dd;
    WB_Alu   = alu;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    clrn = 1'b1; wb_wreg = 1'b0; wb_m2reg = 1'b0; stall = 1'b0;
    wb_d = '0; rna = '0; rnb = '0; D = '0; WB_Alu = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 4, 0, 0, 0, 32'h77);
    chk_en = 1'b1;

    // Reset state.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    check("rst_retired", retired, 32'd0);
    check("rst_last_v", 32'(last_v), 32'd0);
    for (int i = 1; i < 32; i++) begin
      step(0, 0, 0, 0, 0, i, 32 - i, 0, 0);
      mid();
      check("rst_read", qa, 32'd0);
    end

    // ALU write to r3.
    step(0, 1, 0, 0, 3, 3, 3, 0, 32'h1234_5678);
    step(0, 0, 0, 0, 0, 3, 0, 0, 0);
    mid();
    check("r3_qa", qa, 32'h1234_5678);
    check("r3_retired", retired, 32'd1);
    check("r3_last_d", 32'(last_d), 32'd3);
    check("r3_last_v", 32'(last_v), 32'd1);

    // Memory write to r5, then a discarded write to r0.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 5, 0, 0, 32'h5, 32'h14);
    mid();
    check("r5_wb_data", wb_data, 32'h5);
    step(0, 1, 0, 0, 0, 0, 5, 0, 32'hFFFF_FFFF);
    mid();
    check("r5_qb", qb, 32'h5);
    check("r0_wb_data", wb_data, 32'hFFFF_FFFF);
    step(0, 0, 0, 0, 0, 0, 5, 0, 0);
    mid();
    check("r0_qa", qa, 32'd0);
    check("r0_retired", retired, 32'd1);
    check("r0_last_d", 32'(last_d), 32'd5);

    // Same-cycle read of a register being written.
    step(0, 1, 0, 0, 7, 7, 7, 0, 32'hA5A5_A5A5);
    mid();
    check("bypass_qa", qa, Bypass ? 32'hA5A5_A5A5 : 32'd0);
    check("bypass_qb", qb, Bypass ? 32'hA5A5_A5A5 : 32'd0);
    step(0, 0, 0, 0, 0, 7, 7, 0, 0);
    mid();
    check("r7_qa", qa, 32'hA5A5_A5A5);

    // Stalled write is dropped.
    step(0, 1, 0, 1, 9, 9, 9, 0, 32'h9);
    step(0, 0, 0, 0, 0, 9, 9, 0, 0);
    mid();
    check("stall_r9", qa, 32'd0);
    check("stall_retired", retired, 32'd2);

    // Reset coincident with a write to r2 wins.
    step(0, 1, 0, 0, 2, 2, 2, 0, 32'h22);
    step(1, 1, 0, 0, 2, 2, 2, 0, 32'h33);
    step(0, 0, 0, 0, 0, 2, 7, 0, 0);
    mid();
    check("clr_r2", qa, 32'd0);
    check("clr_r7", qb, 32'd0);
    check("clr_retired", retired, 32'd0);
    check("clr_last_v", 32'(last_v), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int a;
      a = $urandom_range(31);
      step($urandom_range(49) == 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
           $urandom_range(4) == 0, ($urandom_range(7) == 0) ? 0 : $urandom_range(31),
           a, ($urandom_range(3) == 0) ? a : $urandom_range(31), $urandom, $urandom);
    end

    // Counter wrap: preset to all-ones, then one commit.
    step(0, 1, 0, 0, 4, 4, 4, 0, 32'h44);
    @(negedge clk);
    #1;
    force dut.retired_q = 32'hFFFF_FFFF;
    release dut.retired_q;
    force_pending = 1'b1;
    @(posedge clk);
    #1;
    force_pending = 1'b0;
    clrn = 1'b0; wb_wreg = 1'b0; stall = 1'b0; wb_d = '0; rna = 5'd4; rnb = 5'd0;
    mid();
    check("wrap_retired", retired, 32'd0);
    check("wrap_last_d", 32'(last_d), 32'd4);
    check("wrap_r4", qa, 32'h44);

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter: WIDTH, 32, data width of every register and data port.
REQ-002 Parameter: AW, 5, register address width; register count is 2**AW.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: clrn  input  1  reset; synchronous, active-high (asserted = 1).
REQ-005 Port: wb_wreg  input  1  write-back enable from MEM/WB latch.
REQ-006 Port: wb_m2reg  input  1  result select: 1 = memory data, 0 = ALU result.
REQ-007 Port: wb_d  input  AW  destination register number.
REQ-008 Port: D  input  WIDTH  load data from MEM/WB latch.
REQ-009 Port: WB_Alu  input  WIDTH  ALU result from MEM/WB latch.
REQ-010 Port: stall  input  1  hold: blocks the write and the counter update this cycle.
REQ-011 Port: rna, rnb  input  AW each  read addresses, ports A and B.
REQ-012 Port: qa, qb  output  WIDTH each  read data, ports A and B.
REQ-013 Port: wb_data  output  WIDTH  selected write-back value; combinational mux of D/WB_Alu.
REQ-014 Port: retired  output  32  count of committed register writes.
REQ-015 Port: last_d, last_v  output  AW, 1  registered destination and valid of the most recent committed write.

Function
REQ-016 wb_data SHALL equal D when wb_m2reg=1, else WB_Alu, in the same cycle.
REQ-017 Commit condition SHALL be wb_wreg=1, stall=0, wb_d!=0 and clrn=0.
REQ-018 On commit, reg[wb_d] SHALL take wb_data at the rising edge; no other register changes.
REQ-019 Register 0 SHALL always read 0; writes to it are discarded and not counted.
REQ-020 qa/qb SHALL be combinational reads of reg[rna]/reg[rnb]; latency 0.
REQ-021 retired SHALL increment by 1 per commit and wrap from 0xFFFFFFFF to 0 without a flag.
REQ-022 On commit, last_d SHALL take wb_d and last_v SHALL become 1; on a non-commit cycle, both hold.
REQ-023 stall=1 with wb_wreg=1 SHALL discard the write; the MEM/WB latch is responsible for re-presenting it.
REQ-024 rna=rnb SHALL return identical data on both ports.

Reset
REQ-025 With clrn=1 at a rising edge, all registers, retired, last_d and last_v SHALL become 0; this overrides any concurrent commit.
REQ-026 A reset asserted between writes SHALL lose earlier writes; the first commit after release behaves as from power-up.

Configuration
REQ-027 Macro WB_BYPASS_EN defined: when a commit is pending with wb_d=rna (or rnb) and wb_d!=0, qa (or qb) SHALL return wb_data in that same cycle.
REQ-028 WB_BYPASS_EN undefined: qa/qb SHALL return the pre-edge register contents; the new value is visible the cycle after commit.

Structure
REQ-029 WIDTH/AW defaults and the zero-register index SHALL live in the shared pipeline package with the other stage constants.
REQ-030 The storage array SHALL be a sub-module regfile_core (1 write port, 2 async read ports); selection, bypass, counter and last-write tracking stay in wb_regfile.

Verification
REQ-031 Reset, then read r1..r31 -> all 0; retired=0; last_v=0.
REQ-032 wb_wreg=1, wb_m2reg=0, wb_d=3, WB_Alu=0x12345678 for one cycle -> next cycle qa(rna=3)=0x12345678, retired=1, last_d=3, last_v=1.
REQ-033 wb_wreg=1, wb_m2reg=1, wb_d=5, D=0x00000005, WB_Alu=0x14 -> r5=0x5; then wb_d=0, WB_Alu=0xFFFFFFFF -> qa(rna=0)=0, retired unchanged at 1.
REQ-034 Same-cycle write r7=0xA5A5A5A5 with rna=7 -> qa=0xA5A5A5A5 in that cycle with WB_BYPASS_EN, old value (0) without it.
REQ-035 stall=1 with wb_wreg=1, wb_d=9, WB_Alu=0x9 -> r9 stays 0, retired unchanged; clrn=1 coincident with a write to r2 -> r2=0, retired=0.
REQ-036 Preset retired to 0xFFFFFFFF via force, then one commit -> retired=0.
